// File: rtl/vga_pattern_fill_pkg.sv
// Shared mode and state codes for the pattern fill engine.
package vga_pattern_fill_pkg;

  typedef enum logic [1:0] {
    PF_MODE_VSTRIPE = 2'd0,
    PF_MODE_HSTRIPE = 2'd1,
    PF_MODE_CHECKER = 2'd2,
    PF_MODE_SOLID   = 2'd3
  } pf_mode_e;

  typedef enum logic [1:0] {
    PF_IDLE = 2'd0,
    PF_FILL = 2'd1,
    PF_DONE = 2'd2
  } pf_state_e;

endpackage

// File: rtl/vga_pattern_fill_xy_scan_counter.sv
// Row-inner two-level pixel counter: row steps on every advance, column steps when row wraps.
module xy_scan_counter #(
  parameter int W_COL = 8,
  parameter int W_ROW = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iClear,
  input  logic             iAdvance,
  output logic [W_COL-1:0] oCol,
  output logic [W_ROW-1:0] oRow,
  output logic             oLast
);

  always_ff @(posedge Clock) begin
    if (Reset || iClear) begin
      oCol <= '0;
      oRow <= '0;
    end else if (iAdvance) begin
      if (oRow == '1) begin
        oRow <= '0;
        oCol <= oCol + W_COL'(1);
      end else begin
        oRow <= oRow + W_ROW'(1);
      end
    end
  end

  assign oLast = (oRow == '1) && (oCol == '1);

endmodule

// File: rtl/vga_pattern_fill.sv
// Banded colour fill engine writing one pixel per accepted RAM cycle.
// Optional border override enabled with the FILL_BORDER_EN macro.
module vga_pattern_fill
  import vga_pattern_fill_pkg::*;
#(
  parameter int H_RES      = 256,
  parameter int V_RES      = 256,
  parameter int BANDS_LOG2 = 2,
  parameter int COLOR_W    = 3,
  parameter int ADDR_W     = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic [1:0]         iMode,
  input  logic [COLOR_W-1:0] iColorA,
  input  logic [COLOR_W-1:0] iColorB,
`ifdef FILL_BORDER_EN
  input  logic [COLOR_W-1:0] iBorderColor,
`endif
  input  logic               iWriteReady,
  output logic               oWriteEnable,
  output logic [ADDR_W-1:0]  oWriteAddress,
  output logic [COLOR_W-1:0] oWriteData,
  output logic               oBusy,
  output logic               oDone
);

  localparam int CW = $clog2(H_RES);
  localparam int RW = $clog2(V_RES);

  pf_state_e          state, state_nxt;
  pf_mode_e           mode_lat;
  logic [COLOR_W-1:0] color_a_lat, color_b_lat;
`ifdef FILL_BORDER_EN
  logic [COLOR_W-1:0] border_lat;
`endif
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic               last, clear, advance, start_acc;
  logic [COLOR_W-1:0] pix;
  logic [ADDR_W-1:0]  addr;

  function automatic logic [COLOR_W-1:0] band_color(
    input pf_mode_e m, input logic cbit, input logic rbit,
    input logic [COLOR_W-1:0] a, input logic [COLOR_W-1:0] b);
    logic odd;
    case (m)
      PF_MODE_VSTRIPE: odd = cbit;
      PF_MODE_HSTRIPE: odd = rbit;
      PF_MODE_CHECKER: odd = cbit ^ rbit;
      default:         odd = 1'b0;
    endcase
    return odd ? b : a;
  endfunction

  assign start_acc = (state == PF_IDLE) && iStart;

  always_ff @(posedge Clock) begin
    if (Reset) state <= PF_IDLE;
    else       state <= state_nxt;
  end

  // Configuration is captured only on an accepted start; later input changes are ignored.
  always_ff @(posedge Clock) begin
    if (start_acc) begin
      mode_lat    <= pf_mode_e'(iMode);
      color_a_lat <= iColorA;
      color_b_lat <= iColorB;
`ifdef FILL_BORDER_EN
      border_lat  <= iBorderColor;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    advance   = 1'b0;
    case (state)
      PF_IDLE: if (iStart) begin
        state_nxt = PF_FILL;
        clear     = 1'b1;
      end
      PF_FILL: if (iWriteReady) begin
        advance = 1'b1;
        if (last) state_nxt = PF_DONE;
      end
      PF_DONE: state_nxt = PF_IDLE;
      default: state_nxt = PF_IDLE;
    endcase
  end

  xy_scan_counter #(.W_COL(CW), .W_ROW(RW)) u_scan (
    .Clock    (Clock),
    .Reset    (Reset),
    .iClear   (clear),
    .iAdvance (advance),
    .oCol     (col),
    .oRow     (row),
    .oLast    (last)
  );

  always_comb begin
    pix = band_color(mode_lat, col[CW-BANDS_LOG2], row[RW-BANDS_LOG2],
                     color_a_lat, color_b_lat);
`ifdef FILL_BORDER_EN
    if (row == '0 || row == '1 || col == '0 || col == '1) pix = border_lat;
`endif
  end

  always_comb begin
    addr = '0;
    addr[RW+CW-1:0] = {row, col};
  end

  assign oWriteEnable  = (state == PF_FILL);
  assign oWriteAddress = oWriteEnable ? addr : '0;
  assign oWriteData    = oWriteEnable ? pix : '0;
  assign oBusy         = (state == PF_FILL) || (state == PF_DONE);
  assign oDone         = (state == PF_DONE);

endmodule

// File: tb/tb_vga_pattern_fill.sv
// Table-driven scoreboard bench for vga_pattern_fill on an 8x8 frame with 2 bands per axis.
module tb_vga_pattern_fill;

  localparam int NPIX = 64;
`ifdef FILL_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset, iStart, iWriteReady;
  logic [1:0]  iMode;
  logic [2:0]  iColorA, iColorB, iBorderColor;
  logic        oWriteEnable, oBusy, oDone;
  logic [15:0] oWriteAddress;
  logic [2:0]  oWriteData;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] mode;
    logic [2:0] ca, cb, bc;
    int         rstyle;     // 0 always ready, 1 ready on odd cycles, 2 stall every third cycle
    int         restart_k;  // write cycle on which a stray start is pulsed, -1 for none
    int         exp_done;   // cycle index of the oDone pulse (start edge = cycle 0)
    int         exp_writes;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [2:0]  data;
  } wr_t;

  vec_t tbl[5];
  wr_t  q[$];

  always #5 clk = ~clk;

  vga_pattern_fill #(
    .H_RES(8), .V_RES(8), .BANDS_LOG2(1), .COLOR_W(3), .ADDR_W(16)
  ) dut (
    .Clock         (clk),
    .Reset         (Reset),
    .iStart        (iStart),
    .iMode         (iMode),
    .iColorA       (iColorA),
    .iColorB       (iColorB),
`ifdef FILL_BORDER_EN
    .iBorderColor  (iBorderColor),
`endif
    .iWriteReady   (iWriteReady),
    .oWriteEnable  (oWriteEnable),
    .oWriteAddress (oWriteAddress),
    .oWriteData    (oWriteData),
    .oBusy         (oBusy),
    .oDone         (oDone)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_pix(input vec_t v, input int r, input int c);
    logic cbit, rbit, odd;
    logic [2:0] d;
    cbit = (c >= 4);
    rbit = (r >= 4);
    case (v.mode)
      2'd0:    odd = cbit;
      2'd1:    odd = rbit;
      2'd2:    odd = cbit ^ rbit;
      default: odd = 1'b0;
    endcase
    d = odd ? v.cb : v.ca;
    if (BORDER && (r == 0 || r == 7 || c == 0 || c == 7)) d = v.bc;
    return d;
  endfunction

  function automatic logic rdy(input int style, input int k);
    case (style)
      1:       return (k % 2) == 1;
      2:       return (k % 3) != 0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic build_queue(input vec_t v);
    wr_t w;
    q.delete();
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++) begin
        w.addr = 16'(r * 8 + c);
        w.data = exp_pix(v, r, c);
        q.push_back(w);
      end
  endtask

  task automatic start_frame(input vec_t v);
    build_queue(v);
    @(posedge clk); #1;
    iStart = 1'b1; iMode = v.mode; iColorA = v.ca; iColorB = v.cb;
    iBorderColor = v.bc; iWriteReady = 1'b0;
    @(posedge clk); #1;
    iStart = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int k, accepted, done_k, n_bc, n_a;
    wr_t e;
    start_frame(v);
    k = 1; accepted = 0; done_k = -1; n_bc = 0; n_a = 0;
    while (k < 400 && done_k < 0) begin
      iWriteReady = rdy(v.rstyle, k);
      if (k == v.restart_k) begin
        iStart = 1'b1; iMode = 2'd3; iColorA = ~v.ca; iColorB = ~v.cb; iBorderColor = ~v.bc;
      end else begin
        iStart = 1'b0;
      end
      @(negedge clk);
      if (oDone) begin
        done_k = k;
        chk("we_in_done", int'(oWriteEnable), 0);
        chk("busy_in_done", int'(oBusy), 1);
      end else if (oWriteEnable) begin
        chk("busy_in_fill", int'(oBusy), 1);
        if (q.size() == 0) begin
          chk("extra_write", 1, 0);
        end else begin
          e = q[0];
          chk(iWriteReady ? "wr_addr" : "stall_addr", int'(oWriteAddress), int'(e.addr));
          chk(iWriteReady ? "wr_data" : "stall_data", int'(oWriteData), int'(e.data));
          if (iWriteReady) begin
            void'(q.pop_front());
            accepted++;
            if (oWriteData == v.bc) n_bc++;
            if (oWriteData == v.ca) n_a++;
          end
        end
      end
      @(posedge clk); #1;
      k++;
    end
    iStart = 1'b0;
    chk("done_cycle", done_k, v.exp_done);
    chk("accepts", accepted, v.exp_writes);
    chk("queue_left", q.size(), 0);
    if (BORDER && v.mode == 2'd3 && v.ca == 3'b100 && v.bc == 3'b001) begin
      chk("border_pixels", n_bc, 28);
      chk("interior_pixels", n_a, 36);
    end
    @(negedge clk);
    chk("done_pulse_end", int'(oDone), 0);
    chk("idle_busy", int'(oBusy), 0);
    chk("idle_we", int'(oWriteEnable), 0);
  endtask

  initial begin
    wr_t e;
    tbl[0] = '{mode: 2'd0, ca: 3'b111, cb: 3'b110, bc: 3'b001, rstyle: 0, restart_k: -1, exp_done: 65,  exp_writes: NPIX};
    tbl[1] = '{mode: 2'd1, ca: 3'b010, cb: 3'b101, bc: 3'b011, rstyle: 0, restart_k: -1, exp_done: 65,  exp_writes: NPIX};
    tbl[2] = '{mode: 2'd2, ca: 3'b001, cb: 3'b100, bc: 3'b111, rstyle: 1, restart_k: -1, exp_done: 128, exp_writes: NPIX};
    tbl[3] = '{mode: 2'd0, ca: 3'b101, cb: 3'b011, bc: 3'b110, rstyle: 0, restart_k: 10, exp_done: 65,  exp_writes: NPIX};
    tbl[4] = '{mode: 2'd3, ca: 3'b100, cb: 3'b000, bc: 3'b001, rstyle: 2, restart_k: -1, exp_done: 96,  exp_writes: NPIX};

    // Reset held two cycles with a start request that must lose to reset.
    Reset = 1'b1; iStart = 1'b1; iMode = 2'd2; iColorA = 3'b111; iColorB = 3'b111;
    iBorderColor = 3'b111; iWriteReady = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we", int'(oWriteEnable), 0);
    chk("rst_addr", int'(oWriteAddress), 0);
    chk("rst_data", int'(oWriteData), 0);
    chk("rst_busy", int'(oBusy), 0);
    chk("rst_done", int'(oDone), 0);
    @(posedge clk); #1;
    Reset = 1'b0; iStart = 1'b0;
    @(negedge clk);
    chk("post_rst_we", int'(oWriteEnable), 0);
    chk("post_rst_busy", int'(oBusy), 0);

    for (int i = 0; i < 5; i++) run_frame(tbl[i]);

    // Reset in the middle of a fill: writes stop, no done pulse.
    start_frame(tbl[1]);
    iWriteReady = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      e = q.pop_front();
      chk("pre_rst_we", int'(oWriteEnable), 1);
      chk("pre_rst_addr", int'(oWriteAddress), int'(e.addr));
      @(posedge clk); #1;
    end
    Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    @(negedge clk);
    chk("midrst_we", int'(oWriteEnable), 0);
    chk("midrst_busy", int'(oBusy), 0);
    chk("midrst_done", int'(oDone), 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("midrst_quiet", int'(oWriteEnable | oDone), 0);
    end
    run_frame(tbl[1]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
